// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU, result {remainder, quotient}
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   dividend_i,
   input  logic [WIDTH-1:0]   divisor_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stall_o
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
   state_t             state_q, state_d;
   logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic               qneg_q, qneg_d, rneg_q, rneg_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] res_q, res_d;
   logic [WIDTH:0]     sh, sub;
   logic               ge;
   // next-state and datapath: quo_q shifts the dividend out and the quotient in
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      sh      = {rem_q, quo_q[WIDTH-1]};
      sub     = sh - {1'b0, dvs_q};
      ge      = sh[WIDTH] | ~sub[WIDTH];
      case (state_q)
         FREE: begin
            if (start_i && divisor_i == '0) begin
               state_d = BYZERO;
            end else if (start_i) begin
               state_d = ON;
               quo_d   = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
               dvs_d   = (signed_i && divisor_i[WIDTH-1]) ? -divisor_i : divisor_i;
               qneg_d  = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
               rneg_d  = signed_i & dividend_i[WIDTH-1];
               rem_d   = '0;
               cnt_d   = '0;
            end
         end
         BYZERO: begin
            state_d = END;
            res_d   = '0;
         end
         ON: begin
            if (cnt_q == CW'(WIDTH)) begin
               state_d = END;
               res_d   = {rneg_q ? -rem_q : rem_q, qneg_q ? -quo_q : quo_q};
            end else begin
               cnt_d = cnt_q + 1'b1;
               rem_d = ge ? sub[WIDTH-1:0] : sh[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], ge};
            end
         end
         END: begin
            if (!start_i) begin
               state_d = FREE;
               res_d   = '0;
            end
         end
      endcase
      if (annul_i) begin
         state_d = FREE;
         res_d   = '0;
         cnt_d   = '0;
      end
   end
   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= FREE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end
   assign result_o = res_q;
   assign ready_o  = (state_q == END);
   assign stall_o  = start_i & ~ready_o;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit against an arithmetic reference
module tb_div_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        signed_i = 1'b0;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stall_o;
   int          tests = 0;
   int          failed = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
      .dividend_i(dividend_i), .divisor_i(divisor_i), .annul_i(annul_i),
      .result_o(result_o), .ready_o(ready_o), .stall_o(stall_o)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 0) return 64'd0;
      sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // called at a negedge; drives start now (cycle 0), leaves at a negedge with start low one cycle
   task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp;
      int cyc;
      int lat;
      exp = model(sg, a, b);
      lat = (b == 0) ? 2 : 34;
      start_i = 1'b1; signed_i = sg; dividend_i = a; divisor_i = b;
      #1 chk("stall_c0", 64'(stall_o), 64'd1);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            dividend_i = $urandom; divisor_i = $urandom; signed_i = ~sg;
         end
      end while (!ready_o && cyc < 100);
      chk("latency", 64'(cyc), 64'(lat));
      chk("result", result_o, exp);
      chk("stall_ready", 64'(stall_o), 64'd0);
      repeat (3) @(negedge clk);
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, exp);
      start_i = 1'b0;
      @(negedge clk);
      chk("exit_ready", 64'(ready_o), 64'd0);
      chk("exit_result", result_o, 64'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      bit sg;
      int cyc;
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(ready_o), 64'd0);
      chk("rst_result", result_o, 64'd0);
      chk("rst_stall", 64'(stall_o), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      run_div(1'b0, 32'd100, 32'd7);
      run_div(1'b1, 32'hFFFFFFF9, 32'h00000002);
      run_div(1'b1, 32'h00000007, 32'hFFFFFFFE);
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
      run_div(1'b0, 32'hFFFFFFFF, 32'h00000001);
      run_div(1'b0, 32'h00001234, 32'h00000000);
      run_div(1'b1, 32'h00001234, 32'h00000000);
      // annul in cycle 10, then a fresh 9 / 3
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'hDEADBEEF; divisor_i = 32'd5;
      repeat (10) @(negedge clk);
      annul_i = 1'b1; start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      chk("annul_ready", 64'(ready_o), 64'd0);
      chk("annul_result", result_o, 64'd0);
      @(negedge clk);
      chk("annul_idle", 64'(ready_o), 64'd0);
      run_div(1'b0, 32'd9, 32'd3);
      // start dropped mid-operation: completes, then leaves END on the next edge
      start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'hFFFFFF9C; divisor_i = 32'd9;
      repeat (5) @(negedge clk);
      start_i = 1'b0;
      cyc = 5;
      while (!ready_o && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("drop_latency", 64'(cyc), 64'd34);
      chk("drop_result", result_o, model(1'b1, 32'hFFFFFF9C, 32'd9));
      @(negedge clk);
      chk("drop_exit", 64'(ready_o), 64'd0);
      // reset asserted in cycle 20
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
      repeat (20) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 64'(ready_o), 64'd0);
      chk("midrst_result", result_o, 64'd0);
      rst = 1'b1; start_i = 1'b0;
      @(negedge clk);
      run_div(1'b0, 32'd1000, 32'd3);
      // randomized operands
      for (int i = 0; i < 24; i++) begin
         sg = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom_range(1, 15);
            1: b = -$urandom_range(1, 15);
            2: b = (i % 8 == 0) ? 32'd0 : $urandom;
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         run_div(sg, a, b);
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
